// File: rtl/ttc_cmd_pkg.sv
// Shared types, constants and symbol lookup functions for the TTC command decoder.
package ttc_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_CLEAR  = 3'd0,
        CMD_GPULSE = 3'd1,
        CMD_CAL    = 3'd2,
        CMD_WRREG  = 3'd3,
        CMD_RDREG  = 3'd4,
        CMD_RDTRIG = 3'd5
    } cmd_type_e;

    localparam logic [15:0] SYNC_FRAME = 16'h817E;
    localparam logic [15:0] PLL_FRAME  = 16'hAAAA;

    localparam logic [7:0] SYM_CLEAR  = 8'h5A;
    localparam logic [7:0] SYM_GPULSE = 8'h5C;
    localparam logic [7:0] SYM_CAL    = 8'h63;
    localparam logic [7:0] SYM_WRREG  = 8'h66;
    localparam logic [7:0] SYM_RDREG  = 8'h65;
    localparam logic [7:0] SYM_RDTRIG = 8'h69;

    typedef struct packed {logic vld; logic [4:0] val;} data_dec_t;
    typedef struct packed {logic vld; logic [3:0] pat;} trig_dec_t;
    typedef struct packed {logic vld; cmd_type_e typ;} cmd_dec_t;

    function automatic logic [1:0] cmd_frames(input cmd_type_e t);
        case (t)
            CMD_RDTRIG:          return 2'd1;
            CMD_CAL, CMD_RDREG:  return 2'd2;
            CMD_WRREG:           return 2'd3;
            default:             return 2'd0;
        endcase
    endfunction

    function automatic data_dec_t data_sym_decode(input logic [7:0] s);
        data_dec_t r;
        r.vld = 1'b1;
        r.val = 5'd0;
        case (s)
            8'h6A: r.val = 5'd0;   8'h6C: r.val = 5'd1;   8'h71: r.val = 5'd2;   8'h72: r.val = 5'd3;
            8'h74: r.val = 5'd4;   8'h8B: r.val = 5'd5;   8'h8D: r.val = 5'd6;   8'h8E: r.val = 5'd7;
            8'h93: r.val = 5'd8;   8'h95: r.val = 5'd9;   8'h96: r.val = 5'd10;  8'h99: r.val = 5'd11;
            8'h9A: r.val = 5'd12;  8'h9C: r.val = 5'd13;  8'hA3: r.val = 5'd14;  8'hA5: r.val = 5'd15;
            8'hA6: r.val = 5'd16;  8'hA9: r.val = 5'd17;  8'h59: r.val = 5'd18;  8'hAC: r.val = 5'd19;
            8'hB1: r.val = 5'd20;  8'hB2: r.val = 5'd21;  8'hB4: r.val = 5'd22;  8'hC3: r.val = 5'd23;
            8'hC5: r.val = 5'd24;  8'hC6: r.val = 5'd25;  8'hC9: r.val = 5'd26;  8'hCA: r.val = 5'd27;
            8'hCC: r.val = 5'd28;  8'hD1: r.val = 5'd29;  8'hD2: r.val = 5'd30;  8'hD4: r.val = 5'd31;
            default: r.vld = 1'b0;
        endcase
        return r;
    endfunction

    function automatic trig_dec_t trig_sym_decode(input logic [7:0] s);
        trig_dec_t r;
        r.vld = 1'b1;
        r.pat = 4'd0;
        case (s)
            8'h2B: r.pat = 4'd1;   8'h2D: r.pat = 4'd2;   8'h2E: r.pat = 4'd3;   8'h33: r.pat = 4'd4;
            8'h35: r.pat = 4'd5;   8'h36: r.pat = 4'd6;   8'h39: r.pat = 4'd7;   8'h3A: r.pat = 4'd8;
            8'h3C: r.pat = 4'd9;   8'h4B: r.pat = 4'd10;  8'h4D: r.pat = 4'd11;  8'h4E: r.pat = 4'd12;
            8'h53: r.pat = 4'd13;  8'h55: r.pat = 4'd14;  8'h56: r.pat = 4'd15;
            default: r.vld = 1'b0;
        endcase
        return r;
    endfunction

    function automatic cmd_dec_t cmd_sym_decode(input logic [7:0] s);
        cmd_dec_t r;
        r.vld = 1'b1;
        r.typ = CMD_CLEAR;
        case (s)
            SYM_CLEAR:  r.typ = CMD_CLEAR;
            SYM_GPULSE: r.typ = CMD_GPULSE;
            SYM_CAL:    r.typ = CMD_CAL;
            SYM_WRREG:  r.typ = CMD_WRREG;
            SYM_RDREG:  r.typ = CMD_RDREG;
            SYM_RDTRIG: r.typ = CMD_RDTRIG;
            default:    r.vld = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ttc_cmd_if.sv
// Frame input and decoded-strobe bundle between TTC frame source and command decoder.
interface ttc_cmd_if;
    logic        valid_i;
    logic [15:0] data_i;
    logic        trig_o;
    logic [3:0]  trig_pattern_o;
    logic [4:0]  trig_tag_o;
    logic        cmd_valid_o;
    logic [2:0]  cmd_type_o;
    logic [29:0] cmd_payload_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;

    modport master (
        output valid_i, data_i,
        input  trig_o, trig_pattern_o, trig_tag_o, cmd_valid_o, cmd_type_o,
               cmd_payload_o, err_o, err_cnt_o
    );
    modport slave (
        input  valid_i, data_i,
        output trig_o, trig_pattern_o, trig_tag_o, cmd_valid_o, cmd_type_o,
               cmd_payload_o, err_o, err_cnt_o
    );
endinterface

// File: rtl/ttc_symbol_decode.sv
// Combinational classification of both symbols of one 16-bit TTC frame.
import ttc_cmd_pkg::*;

module ttc_symbol_decode (
    input  logic [15:0] frame_i,
    output data_dec_t   a_data_o,
    output data_dec_t   b_data_o,
    output trig_dec_t   a_trig_o,
    output cmd_dec_t    a_cmd_o,
    output logic        is_sync_o,
    output logic        is_pll_o
);
    assign a_data_o  = data_sym_decode(frame_i[15:8]);
    assign b_data_o  = data_sym_decode(frame_i[7:0]);
    assign a_trig_o  = trig_sym_decode(frame_i[15:8]);
    assign a_cmd_o   = cmd_sym_decode(frame_i[15:8]);
    assign is_sync_o = (frame_i == SYNC_FRAME);
    assign is_pll_o  = (frame_i == PLL_FRAME);
endmodule

// File: rtl/ttc_cmd_decoder.sv
// RD53B-style TTC command decoder: triggers, multi-frame commands, protocol errors.
// Optional saturating error counter enabled with TTC_CMD_ERR_CNT_EN.
import ttc_cmd_pkg::*;

module ttc_cmd_decoder #(
    parameter logic [3:0] CHIP_ID = 4'h0
) (
    input logic      clk,
    input logic      reset,
    ttc_cmd_if.slave bus
);
    typedef enum logic {IDLE, PAYLOAD} state_e;

    data_dec_t a_data, b_data;
    trig_dec_t a_trig;
    cmd_dec_t  a_cmd;
    logic      is_sync, is_pll;

    ttc_symbol_decode u_symdec (
        .frame_i  (bus.data_i),
        .a_data_o (a_data),
        .b_data_o (b_data),
        .a_trig_o (a_trig),
        .a_cmd_o  (a_cmd),
        .is_sync_o(is_sync),
        .is_pll_o (is_pll)
    );

    state_e      state_q, state_d;
    cmd_type_e   ctype_q, ctype_d;
    logic        id_ok_q, id_ok_d;
    logic [1:0]  nfrm_q, nfrm_d, frm_idx_q, frm_idx_d;
    logic [29:0] pl_q, pl_d, pl_new;
    logic        trig_q, trig_d, cmd_vld_q, cmd_vld_d, err_q, err_d;
    logic [3:0]  pat_q, pat_d;
    logic [4:0]  tag_q, tag_d;
    logic [2:0]  otype_q, otype_d;
    logic [29:0] opl_q, opl_d;
    logic        id_match;

    assign id_match = b_data.vld && (b_data.val[4] || (b_data.val[3:0] == CHIP_ID));

    // Payload frames land MSB-first, so shorter commands come out zero-filled in the LSBs.
    always_comb begin
        pl_new = pl_q;
        case (frm_idx_q)
            2'd0:    pl_new = {a_data.val, b_data.val, 20'd0};
            2'd1:    pl_new = {pl_q[29:20], a_data.val, b_data.val, 10'd0};
            default: pl_new = {pl_q[29:10], a_data.val, b_data.val};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ctype_d   = ctype_q;
        id_ok_d   = id_ok_q;
        nfrm_d    = nfrm_q;
        frm_idx_d = frm_idx_q;
        pl_d      = pl_q;
        trig_d    = 1'b0;
        cmd_vld_d = 1'b0;
        err_d     = 1'b0;
        pat_d     = pat_q;
        tag_d     = tag_q;
        otype_d   = otype_q;
        opl_d     = opl_q;
        if (bus.valid_i) begin
            case (state_q)
                IDLE: begin
                    if (is_sync || is_pll) begin
                        state_d = IDLE;
                    end else if (a_trig.vld && b_data.vld) begin
                        trig_d = 1'b1;
                        pat_d  = a_trig.pat;
                        tag_d  = b_data.val;
                    end else if (a_cmd.vld && b_data.vld) begin
                        ctype_d = a_cmd.typ;
                        id_ok_d = id_match;
                        nfrm_d  = cmd_frames(a_cmd.typ);
                        if (cmd_frames(a_cmd.typ) == 2'd0) begin
                            if (id_match) begin
                                cmd_vld_d = 1'b1;
                                otype_d   = a_cmd.typ;
                                opl_d     = '0;
                            end
                        end else begin
                            pl_d      = '0;
                            frm_idx_d = 2'd0;
                            state_d   = PAYLOAD;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    if (is_pll) begin
                        state_d = PAYLOAD;
                    end else if (a_data.vld && b_data.vld) begin
                        pl_d      = pl_new;
                        frm_idx_d = frm_idx_q + 2'd1;
                        if (frm_idx_q + 2'd1 == nfrm_q) begin
                            state_d = IDLE;
                            if (id_ok_q) begin
                                cmd_vld_d = 1'b1;
                                otype_d   = ctype_q;
                                opl_d     = pl_new;
                            end
                        end
                    end else if (a_trig.vld && b_data.vld) begin
                        trig_d = 1'b1;
                        pat_d  = a_trig.pat;
                        tag_d  = b_data.val;
                    end else begin
                        // Sync, command or garbage aborts; the frame is not re-decoded in IDLE.
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ctype_q   <= CMD_CLEAR;
            id_ok_q   <= 1'b0;
            nfrm_q    <= 2'd0;
            frm_idx_q <= 2'd0;
            pl_q      <= '0;
            trig_q    <= 1'b0;
            cmd_vld_q <= 1'b0;
            err_q     <= 1'b0;
            pat_q     <= '0;
            tag_q     <= '0;
            otype_q   <= '0;
            opl_q     <= '0;
        end else begin
            state_q   <= state_d;
            ctype_q   <= ctype_d;
            id_ok_q   <= id_ok_d;
            nfrm_q    <= nfrm_d;
            frm_idx_q <= frm_idx_d;
            pl_q      <= pl_d;
            trig_q    <= trig_d;
            cmd_vld_q <= cmd_vld_d;
            err_q     <= err_d;
            pat_q     <= pat_d;
            tag_q     <= tag_d;
            otype_q   <= otype_d;
            opl_q     <= opl_d;
        end
    end

`ifdef TTC_CMD_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
    always_ff @(posedge clk) begin
        if (reset) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end
    assign bus.err_cnt_o = err_cnt_q;
`else
    assign bus.err_cnt_o = 8'd0;
`endif

    assign bus.trig_o         = trig_q;
    assign bus.trig_pattern_o = pat_q;
    assign bus.trig_tag_o     = tag_q;
    assign bus.cmd_valid_o    = cmd_vld_q;
    assign bus.cmd_type_o     = otype_q;
    assign bus.cmd_payload_o  = opl_q;
    assign bus.err_o          = err_q;
endmodule

// File: tb/tb_ttc_cmd_decoder.sv
// Scoreboard bench: stimulus pushes expected strobes, a negedge monitor pops and compares.
module tb_ttc_cmd_decoder;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_err_exp = 0;

    ttc_cmd_if bus();

    ttc_cmd_decoder #(.CHIP_ID(4'h0)) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [7:0] DSYM [32] = '{
        8'h6A, 8'h6C, 8'h71, 8'h72, 8'h74, 8'h8B, 8'h8D, 8'h8E,
        8'h93, 8'h95, 8'h96, 8'h99, 8'h9A, 8'h9C, 8'hA3, 8'hA5,
        8'hA6, 8'hA9, 8'h59, 8'hAC, 8'hB1, 8'hB2, 8'hB4, 8'hC3,
        8'hC5, 8'hC6, 8'hC9, 8'hCA, 8'hCC, 8'hD1, 8'hD2, 8'hD4};

    typedef struct {
        int          kind;  // 0 trigger, 1 command, 2 error
        int          cyc;
        logic [3:0]  pat;
        logic [4:0]  tag;
        logic [2:0]  ctype;
        logic [29:0] pl;
        bit          chk_pl;
    } exp_t;
    exp_t expq[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic take(input int kind);
        exp_t e;
        if (expq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_strobe: got strobe kind %0d expected none (cycle %0d)", kind, cyc);
        end else begin
            e = expq.pop_front();
            chk("strobe_kind", kind, e.kind);
            chk("strobe_latency", cyc, e.cyc);
            if (kind == 0 && e.kind == 0) begin
                chk("trig_pattern", bus.trig_pattern_o, e.pat);
                chk("trig_tag", bus.trig_tag_o, e.tag);
            end else if (kind == 1 && e.kind == 1) begin
                chk("cmd_type", bus.cmd_type_o, e.ctype);
                if (e.chk_pl) chk("cmd_payload", bus.cmd_payload_o, e.pl);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.trig_o || bus.cmd_valid_o || bus.err_o)
                chk("single_strobe", {31'd0, bus.trig_o & bus.cmd_valid_o}, 32'd0);
            if (bus.trig_o)      take(0);
            if (bus.cmd_valid_o) take(1);
            if (bus.err_o)       take(2);
        end
    end

    task automatic push(input int kind, input logic [3:0] pat, input logic [4:0] tag,
                        input logic [2:0] ct, input logic [29:0] pl, input bit cp);
        exp_t e;
        e.kind = kind; e.cyc = cyc + 1; e.pat = pat; e.tag = tag;
        e.ctype = ct; e.pl = pl; e.chk_pl = cp;
        expq.push_back(e);
    endtask
    task automatic exp_trig(input logic [3:0] p, input logic [4:0] t); push(0, p, t, 3'd0, 30'd0, 1'b0); endtask
    task automatic exp_cmd(input logic [2:0] ct, input logic [29:0] pl, input bit cp); push(1, 4'd0, 5'd0, ct, pl, cp); endtask
    task automatic exp_err(); n_err_exp++; push(2, 4'd0, 5'd0, 3'd0, 30'd0, 1'b0); endtask

    task automatic send(input logic [15:0] w);
        @(posedge clk); #1;
        bus.valid_i = 1'b1;
        bus.data_i  = w;
    endtask
    task automatic send_nv(input logic [15:0] w);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        bus.data_i  = w;
    endtask
    task automatic send_d10(input logic [9:0] v);
        send({DSYM[v[9:5]], DSYM[v[4:0]]});
    endtask

    task automatic drain();
        int k = 0;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        bus.data_i  = 16'h0;
        while (expq.size() != 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk); #1;
        chk("scoreboard_drain", expq.size(), 0);
    endtask

    task automatic chk_err_cnt();
`ifdef TTC_CMD_ERR_CNT_EN
        chk("err_cnt", bus.err_cnt_o, n_err_exp);
`else
        chk("err_cnt", bus.err_cnt_o, 0);
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_trig"}, bus.trig_o, 0);
        chk({tag, "_pattern"}, bus.trig_pattern_o, 0);
        chk({tag, "_tag"}, bus.trig_tag_o, 0);
        chk({tag, "_cmd_valid"}, bus.cmd_valid_o, 0);
        chk({tag, "_cmd_type"}, bus.cmd_type_o, 0);
        chk({tag, "_payload"}, bus.cmd_payload_o, 0);
        chk({tag, "_err"}, bus.err_o, 0);
        chk({tag, "_err_cnt"}, bus.err_cnt_o, 0);
    endtask

    initial begin
        logic [29:0] wr_pl;
        logic [19:0] cal_v, rd_v;
        rst = 1'b1;
        bus.valid_i = 1'b0;
        bus.data_i  = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Trigger in IDLE
        send(16'h2B6C); exp_trig(4'd1, 5'd1);
        drain();

        // Clear: own ID, foreign ID (silent), broadcast ID
        send(16'h5A6A); exp_cmd(3'd0, 30'd0, 1'b0);
        send(16'h5A6C);
        send(16'h5AA6); exp_cmd(3'd0, 30'd0, 1'b0);
        drain();

        // WrReg addr 0x025 data 0xBEEF, back-to-back frames
        wr_pl = {9'h025, 16'hBEEF, 5'h00};
        send(16'h666A);
        send_d10(wr_pl[29:20]);
        send_d10(wr_pl[19:10]);
        send_d10(wr_pl[9:0]); exp_cmd(3'd3, wr_pl, 1'b1);
        drain();
        chk("wrreg_addr_hold", bus.cmd_payload_o[29:21], 9'h025);
        chk("wrreg_data_hold", bus.cmd_payload_o[20:5], 16'hBEEF);

        // Cal with PLL filler, an invalid-cycle frame and a trigger between payload frames
        cal_v = 20'h12345;
        send(16'h636A);
        send_d10(cal_v[19:10]);
        send(16'hAAAA);
        send_nv(16'h0000);
        send(16'h2D71); exp_trig(4'd2, 5'd2);
        send_d10(cal_v[9:0]); exp_cmd(3'd2, {cal_v, 10'd0}, 1'b1);
        drain();

        // WrReg aborted by Sync, then Clear decodes normally
        send(16'h666A);
        send_d10(10'h155);
        send(16'h817E); exp_err();
        send(16'h5A6A); exp_cmd(3'd0, 30'd0, 1'b0);
        drain();
        chk_err_cnt();

        // GlobalPulse, ReadTrigger, command symbol mid-payload, foreign-ID WrReg drop
        send(16'h5C6A); exp_cmd(3'd1, 30'd0, 1'b0);
        send(16'h696A);
        send_d10(10'h2A5); exp_cmd(3'd5, {10'h2A5, 20'd0}, 1'b1);
        send(16'h636A);
        send(16'h5A6A); exp_err();
        send(16'h2B6C); exp_trig(4'd1, 5'd1);
        send(16'h666C);
        send_d10(10'h001);
        send_d10(10'h002);
        send_d10(10'h003);
        drain();

        // Garbage frame in IDLE
        send(16'h0000); exp_err();
        drain();
        chk_err_cnt();

        // Reset in the middle of a RdReg payload
        send(16'h656A);
        send_d10(10'h3FF);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("midreset");
        n_err_exp = 0;
        @(posedge clk); #1;
        rst = 1'b0;

        rd_v = 20'hABCDE;
        send(16'h656A);
        send_d10(rd_v[19:10]);
        send_d10(rd_v[9:0]); exp_cmd(3'd4, {rd_v, 10'd0}, 1'b1);
        drain();
        chk_err_cnt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ttc_cmd_decoder.md
Name: ttc_cmd_decoder

Overview:
- Consumes the aligned 16-bit TTC frames (valid + word) from the TTC input decoder.
- Decodes RD53B-style command traffic:
  - triggers
  - Clear, GlobalPulse, Cal, WrReg, RdReg, ReadTrigger
  - Sync and PLL-lock filler frames
- Emits single-cycle registered strobes with decoded fields to the emulator core and register file.
- Collects multi-frame command payloads and lets trigger frames interleave inside a command.

Parameters:
- CHIP_ID, 4'h0, local chip ID; a command is accepted when its ID symbol matches this value or has broadcast bit [4] set.

Ports:
- clk  in  1  DAQ-forwarded clock
- reset  in  1  synchronous active-high reset
- valid_i  in  1  input frame valid, at most one per cycle
- data_i  in  16  frame: [15:8] symbol A, [7:0] symbol B
- trig_o  out  1  trigger strobe
- trig_pattern_o  out  4  4-bit bunch-crossing pattern, nonzero
- trig_tag_o  out  5  trigger tag
- cmd_valid_o  out  1  command strobe, ID matched
- cmd_type_o  out  3  0 Clear, 1 GlobalPulse, 2 Cal, 3 WrReg, 4 RdReg, 5 ReadTrigger
- cmd_payload_o  out  30  collected data symbols, first symbol in MSBs, zero-filled in LSBs
- err_o  out  1  protocol error strobe
- err_cnt_o  out  8  error count (optional feature)

Behaviour:
- All outputs are registered and reset to 0. Strobes are high for exactly one cycle. Fields hold their last value when the strobe is low.
- Latency: a strobe asserts 1 cycle after the valid_i frame that completes the item.
- Frames with valid_i=0 are ignored; FSM state and counters hold.
- Symbol classes come from package LUTs:
  - 32 data symbols map to 5-bit values (0x6A→0, 0x6C→1, 0x71→2, …, 0xD4→31).
  - 15 trigger symbols map to patterns 1..15 (0x2B→1, 0x2D→2, …, 0x56→15).
  - Command symbols: 0x5A Clear, 0x5C GlobalPulse, 0x63 Cal, 0x66 WrReg, 0x65 RdReg, 0x69 ReadTrigger.
- Special frames are whole 16-bit words: 0x817E Sync, 0xAAAA PLL-lock.
- FSM states: IDLE, PAYLOAD.
- IDLE:
  - Sync or PLL-lock frame → no-op.
  - Trigger frame {trig_sym, data_sym} → trig_o, pattern, tag=data value.
  - Command frame {cmd_sym, data_sym} → latch type, ID match and required payload frame count N.
    - N: Clear 0, GlobalPulse 0, ReadTrigger 1, Cal 2, RdReg 2, WrReg 3.
    - N=0 → cmd_valid_o next cycle if ID matched; stay in IDLE.
    - N>0 → clear payload, go to PAYLOAD.
  - Anything else → err_o.
- PAYLOAD:
  - Data frame {data_sym, data_sym} → shift 10 bits into payload, decrement count.
  - Last frame → cmd_valid_o if ID matched, else silent drop; return to IDLE.
  - Trigger frame → emit trigger; payload and count are unchanged.
  - PLL-lock frame → no-op.
  - Sync, command or invalid frame → abort command, err_o, return to IDLE. The offending frame is not reinterpreted.
- Payload packing:
  - Final bits [29:0] for WrReg: addr=[29:21], data=[20:5], [4:0] reserved.
  - RdReg addr and Cal fields use bits [29:10] (2 frames); ReadTrigger uses [29:20].
- A trigger and a command never strobe in the same cycle.
- Reset mid-command discards partial payload; FSM returns to IDLE.

Optional Feature:
- Macro: TTC_CMD_ERR_CNT_EN.
- With the macro: err_cnt_o increments on each err_o, saturates at 8'hFF, and is cleared only by reset.
- Without the macro: err_cnt_o is tied to 0 and no counter logic is built.

Decomposition:
- Package ttc_cmd_pkg holds:
  - command type enum
  - SYNC_FRAME and PLL_FRAME constants
  - command symbol constants
  - per-command payload frame count function
  - data-symbol and trigger-symbol decode functions, each returning a valid flag plus value
- Sub-module ttc_symbol_decode is natural: combinational decode of both symbols of a frame into class and value, instanced once.

Test Plan:
- Frame 0x2B6C with CHIP_ID=0 → trig_o one cycle later, pattern=1, tag=1; cmd_valid_o=0.
- Frame 0x5A6A (Clear, ID 0) → cmd_valid_o, type=0. Frame 0x5A6C (ID 1) → no strobe, no error.
- WrReg: 0x666A, then three data frames with payload addr=0x025, data=0xBEEF → cmd_valid_o type=3, payload[29:21]=0x025, payload[20:5]=0xBEEF, exactly 1 cycle after the third frame.
- Cal with trigger 0x2D71 between payload frames 1 and 2 → trig_o with pattern=2, tag=2 mid-command; Cal then completes with the correct 20-bit payload.
- WrReg interrupted by 0x817E after 1 data frame → err_o=1, no cmd_valid_o; next Clear decodes normally. With TTC_CMD_ERR_CNT_EN, err_cnt_o=1.
- Frame 0x0000 in IDLE → err_o. Reset asserted during a RdReg payload → all outputs 0; a subsequent RdReg decodes cleanly.
